instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port stall  input  1  freeze fetch; PC and output register hold.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 SHALL have port redirect_target  input  32  new fetch address.
REQ-007 SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-008 SHALL have port mem_cs, mem_oe, mem_we  output  1 each  instruction-memory chip select, read enable, write enable.
REQ-009 SHALL have port mem_addr  output  32  instruction-memory address; mem_din  output  32  write data.
REQ-010 SHALL have port mem_dout  input  32  instruction-memory read data, combinational from mem_addr.
REQ-011 SHALL have ports instr (32), instr_pc (32), instr_valid (1) as outputs, holding the fetched word, its address and its valid flag.
REQ-012 SHALL have ports fetch_fault (output, 1), a one-cycle misaligned-redirect pulse, and fetch_count (output, 32), the number of delivered instructions.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, STALL; IDLE only for the first cycle after reset release, then FETCH unconditionally.
REQ-014 SHALL drive mem_we=0 and mem_din=32'h0 in all states.
REQ-015 SHALL drive mem_cs=mem_oe=1 in FETCH and 0 in IDLE and STALL; mem_addr=pc in all states.
REQ-016 SHALL, in FETCH with stall=0, redirect_valid=0 and (instr_valid=0 or instr_ready=1), load instr<=mem_dout, instr_pc<=pc, instr_valid<=1, pc<=pc+4, giving a one-cycle address-to-output latency.
REQ-017 SHALL treat a transfer as instr_valid && instr_ready; on a transfer with no new load, clear instr_valid the next cycle.
REQ-018 SHALL hold instr, instr_pc and instr_valid stable while instr_valid=1 and instr_ready=0 (back-pressure), and hold pc unchanged.
REQ-019 SHALL move FETCH->STALL when stall=1 and STALL->FETCH when stall=0; in STALL, pc and the output register are held, but a transfer still clears instr_valid.
REQ-020 SHALL give redirect_valid priority over stall and fetch in FETCH and STALL: pc<={redirect_target[31:2],2'b00}, instr_valid<=0 (flush), no load that cycle, state unchanged.
REQ-021 SHALL ignore redirect_valid in IDLE.
REQ-022 SHALL pulse fetch_fault for exactly one cycle after an accepted redirect with redirect_target[1:0]!=0.
REQ-023 SHALL increment fetch_count by 1 on every transfer, wrapping from 32'hFFFFFFFF to 0.
REQ-024 SHALL compute pc+4 modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-025 SHALL flush a transfer coinciding with a redirect; that transfer still counts.

Reset
REQ-026 SHALL, while rst=1, asynchronously set state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0, fetch_count=0.
REQ-027 SHALL abort any in-progress fetch or held output on mid-operation reset, with no partial update after release.
REQ-028 SHALL issue the first memory read (mem_cs=1, mem_addr=RESET_PC) in the second cycle after reset release.

Structure
REQ-029 SHALL place the FSM state encoding, the default RESET_PC value and the instruction width constant in the shared processor package.
REQ-030 SHALL use one natural sub-module, pc_reg, holding the PC register with load/increment/hold select; output register and FSM stay in instr_fetch.
REQ-031 SHALL connect directly to the existing sram instruction-memory block without glue logic.

Verification
REQ-032 SHALL cover: reset release, instr_ready=1, sram preloaded -> mem_addr 00400000, 00400004, 00400008 on consecutive FETCH cycles; instr_pc follows one cycle later; fetch_count=3 after 3 transfers.
REQ-033 SHALL cover: instr_ready=0 for 4 cycles with instr_valid=1 at instr_pc=00400004 -> instr, instr_pc and pc unchanged; fetch_count unchanged.
REQ-034 SHALL cover: redirect_valid=1, target 0040003C, while stall=1 -> next cycle instr_valid=0 and pc=0040003C; after stall drops, instr_pc=0040003C.
REQ-035 SHALL cover: redirect target 00400052 -> pc=00400050 and fetch_fault high for exactly one cycle.
REQ-036 SHALL cover: RESET_PC=FFFFFFFC -> second delivered instr_pc=00000000.
REQ-037 SHALL cover: rst asserted mid-stream with instr_valid=1 -> outputs zero immediately (asynchronously), before the next clock edge.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_pkg
//  Purpose  : Shared processor-front-end types and constants: fetch FSM
//             encoding, PC update selects, default reset PC, data widths.
//  Revision : 1.0  initial release
// ============================================================================
package instr_fetch_pkg;

  // Widths of the instruction word and of the fetch address.
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // First fetch address after reset unless the instance overrides it.
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // How the PC register moves on the next edge.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  // Force an address onto a word boundary by clearing the byte offset.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_if
//  Purpose  : Instruction-memory bus between the fetch unit (master) and the
//             synchronous-select / combinational-read SRAM (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               mem_cs;
  logic               mem_oe;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_din;
  logic [INSTR_W-1:0] mem_dout;

  // Fetch unit side: drives the request, receives read data.
  modport master (
    output mem_cs,
    output mem_oe,
    output mem_we,
    output mem_addr,
    output mem_din,
    input  mem_dout
  );

  // Memory side: receives the request, returns read data.
  modport slave (
    input  mem_cs,
    input  mem_oe,
    input  mem_we,
    input  mem_addr,
    input  mem_din,
    output mem_dout
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Purpose  : Program counter with hold / +4 / load selection. Loads are
//             word-aligned; the increment wraps modulo 2^32.
//  Revision : 1.0  initial release
// ============================================================================
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: hold, advance one word (natural 32-bit wrap), or jump aligned.
  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:  pc_d = pc_q + 32'd4;
      PC_LOAD: pc_d = word_align(load_addr_i);
      default: pc_d = pc_q;
    endcase
  end

  // PC storage; reset returns to the configured boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage. Reads the word at PC from a
//             combinational-read instruction memory, registers it together
//             with its address for decode, and handles stall, back-pressure
//             and redirects (with misaligned-target fault pulse).
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_target_i,
  input  logic               instr_ready_i,
  instr_fetch_if.master      mem_if,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  output logic               fetch_fault_o,
  output logic [31:0]        fetch_count_o
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               instr_valid_q;
  logic               fetch_fault_q;
  logic [31:0]        fetch_count_q;

  logic [ADDR_W-1:0]  pc;
  pc_sel_e            pc_sel;
  logic               xfer;
  logic               take_redirect;
  logic               take_load;

  // Per-cycle decisions shared by the PC register and the output register.
  // A redirect wins over everything but is meaningless before the first fetch.
  always_comb begin
    xfer          = instr_valid_q & instr_ready_i;
    take_redirect = redirect_valid_i && (state_q != IDLE);
    take_load     = (state_q == FETCH) && !take_redirect && !stall_i &&
                    (!instr_valid_q || instr_ready_i);
    pc_sel        = PC_HOLD;
    if (take_redirect) begin
      pc_sel = PC_LOAD;
    end else if (take_load) begin
      pc_sel = PC_INC;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .sel_i       (pc_sel),
    .load_addr_i (redirect_target_i),
    .pc_o        (pc)
  );

  // Fetch FSM and decode-facing output register. A transfer consumes the
  // held word and is counted even when a redirect flushes in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      fetch_fault_q <= 1'b0;
      if (xfer) begin
        fetch_count_q <= fetch_count_q + 32'd1;
        instr_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
        end
        FETCH: begin
          if (take_redirect) begin
            instr_valid_q <= 1'b0;
            fetch_fault_q <= |redirect_target_i[1:0];
          end else if (stall_i) begin
            state_q <= STALL;
          end else if (take_load) begin
            instr_q       <= mem_if.mem_dout;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
          end
        end
        STALL: begin
          if (take_redirect) begin
            instr_valid_q <= 1'b0;
            fetch_fault_q <= |redirect_target_i[1:0];
          end else if (!stall_i) begin
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory is read-only from here; select/enable only while fetching.
  assign mem_if.mem_cs   = (state_q == FETCH);
  assign mem_if.mem_oe   = (state_q == FETCH);
  assign mem_if.mem_we   = 1'b0;
  assign mem_if.mem_din  = '0;
  assign mem_if.mem_addr = pc;

  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_fault_o = fetch_fault_q;
  assign fetch_count_o = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch: scoreboard of delivered
//             instruction addresses plus cycle-level checks of stall,
//             back-pressure, redirect, fault pulse, PC wrap and async reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall;
  logic        redir_v;
  logic [31:0] redir_t;
  logic        ready;

  logic [31:0] instr, instr_pc, fcount;
  logic        ivalid, fault;
  logic [31:0] instr2, instr_pc2, fcount2;
  logic        ivalid2, fault2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  instr_fetch_if mif ();
  instr_fetch_if mif2 ();

  // Memory image: every address holds a distinct scrambled word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  assign mif.mem_dout  = mem_word(mif.mem_addr);
  assign mif2.mem_dout = mem_word(mif2.mem_addr);

  instr_fetch u_dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall),
    .redirect_valid_i  (redir_v),
    .redirect_target_i (redir_t),
    .instr_ready_i     (ready),
    .mem_if            (mif),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
    .instr_valid_o     (ivalid),
    .fetch_fault_o     (fault),
    .fetch_count_o     (fcount)
  );

  // Second instance boots at the top of the address space to show PC wrap.
  instr_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (1'b0),
    .redirect_valid_i  (1'b0),
    .redirect_target_i (32'h0),
    .instr_ready_i     (1'b1),
    .mem_if            (mif2),
    .instr_o           (instr2),
    .instr_pc_o        (instr_pc2),
    .instr_valid_o     (ivalid2),
    .fetch_fault_o     (fault2),
    .fetch_count_o     (fcount2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each transfer seen by decode must match the next expected address.
  always @(negedge clk) begin
    if (!rst && ivalid && ready) begin
      logic [31:0] e;
      e = 32'hxxxx_xxxx;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check_eq("sb_pc", instr_pc, e);
      check_eq("sb_instr", instr, mem_word(e));
    end
  end

  initial begin
    stall   = 1'b0;
    redir_v = 1'b0;
    redir_t = 32'h0;
    ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", ivalid, 0);
    check_eq("rst_pc", instr_pc, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_count", fcount, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_addr", mif.mem_addr, 32'h0040_0000);
    check_eq("rst_cs", mif.mem_cs, 0);

    // Sequential fetch from reset.
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    exp_q.push_back(32'h0040_0008);
    rst = 1'b0;
    #1;
    check_eq("idle_cs", mif.mem_cs, 0);
    tick();
    check_eq("first_cs", mif.mem_cs, 1);
    check_eq("first_oe", mif.mem_oe, 1);
    check_eq("first_we", mif.mem_we, 0);
    check_eq("first_din", mif.mem_din, 0);
    check_eq("first_addr", mif.mem_addr, 32'h0040_0000);
    tick();
    check_eq("seq_addr1", mif.mem_addr, 32'h0040_0004);
    check_eq("seq_ipc0", instr_pc, 32'h0040_0000);
    check_eq("seq_valid", ivalid, 1);
    check_eq("seq_count0", fcount, 0);
    check_eq("wrap_ipc0", instr_pc2, 32'hFFFF_FFFC);
    tick();
    check_eq("seq_addr2", mif.mem_addr, 32'h0040_0008);
    check_eq("seq_ipc1", instr_pc, 32'h0040_0004);
    check_eq("seq_count1", fcount, 1);
    check_eq("wrap_ipc1", instr_pc2, 32'h0000_0000);
    check_eq("wrap_instr1", instr2, mem_word(32'h0));

    // Back-pressure: decode refuses for four cycles.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_ipc", instr_pc, 32'h0040_0004);
      check_eq("bp_instr", instr, mem_word(32'h0040_0004));
      check_eq("bp_valid", ivalid, 1);
      check_eq("bp_addr", mif.mem_addr, 32'h0040_0008);
      check_eq("bp_count", fcount, 1);
    end
    ready = 1'b1;
    exp_q.push_back(32'h0040_000C);
    tick();
    tick();
    check_eq("seq_count3", fcount, 3);
    check_eq("seq_ipc3", instr_pc, 32'h0040_000C);

    // Redirect during stall, coinciding with the transfer of 0040000C.
    stall   = 1'b1;
    redir_v = 1'b1;
    redir_t = 32'h0040_003C;
    tick();
    redir_v = 1'b0;
    check_eq("rd_valid", ivalid, 0);
    check_eq("rd_addr", mif.mem_addr, 32'h0040_003C);
    check_eq("rd_count", fcount, 4);
    check_eq("rd_fault", fault, 0);
    tick();
    check_eq("stl_cs", mif.mem_cs, 0);
    check_eq("stl_addr", mif.mem_addr, 32'h0040_003C);
    check_eq("stl_valid", ivalid, 0);
    exp_q.push_back(32'h0040_003C);
    stall = 1'b0;
    tick();
    check_eq("unstl_cs", mif.mem_cs, 1);
    check_eq("unstl_valid", ivalid, 0);
    tick();
    check_eq("rd_ipc", instr_pc, 32'h0040_003C);
    check_eq("rd_valid2", ivalid, 1);

    // Misaligned redirect: aligned PC and a single-cycle fault pulse.
    redir_v = 1'b1;
    redir_t = 32'h0040_0052;
    tick();
    redir_v = 1'b0;
    check_eq("mis_fault", fault, 1);
    check_eq("mis_addr", mif.mem_addr, 32'h0040_0050);
    check_eq("mis_valid", ivalid, 0);
    check_eq("mis_count", fcount, 5);
    exp_q.push_back(32'h0040_0050);
    tick();
    check_eq("mis_fault_end", fault, 0);
    check_eq("mis_ipc", instr_pc, 32'h0040_0050);
    check_eq("mis_addr2", mif.mem_addr, 32'h0040_0054);
    tick();
    ready = 1'b0;
    check_eq("end_count", fcount, 6);
    check_eq("end_ipc", instr_pc, 32'h0040_0054);
    check_eq("sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-stream with a held word.
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", ivalid, 0);
    check_eq("ar_pc", instr_pc, 0);
    check_eq("ar_instr", instr, 0);
    check_eq("ar_count", fcount, 0);
    check_eq("ar_addr", mif.mem_addr, 32'h0040_0000);
    check_eq("ar_cs", mif.mem_cs, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_eq("rel_cs", mif.mem_cs, 1);
    check_eq("rel_addr", mif.mem_addr, 32'h0040_0000);
    check_eq("rel_valid", ivalid, 0);
    tick();
    check_eq("rel_ipc", instr_pc, 32'h0040_0000);
    check_eq("rel_valid2", ivalid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
